// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_ctrl
// Brief    : Read-side controller for a sync_fifo with read latency 1.
//            Issues FIFO reads while room exists in a 2-entry output buffer
//            and streams buffered words on a valid/ready interface at up to
//            one word per cycle.
// Options  : define FIFO_RD_CNT_EN to compile in the delivered-word counter
//            (port rd_cnt, wraps at 2^CNT_WIDTH).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,            // asynchronous, active-low
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_cs,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  rd_cnt
`endif
);

   // IDLE : nothing in flight, buffer has room
   // READ : one read in flight (issued last cycle), room still left
   // FULL : occupancy + in-flight has reached the buffer depth of 2
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_occ;        // words held in the output buffer
   logic [1:0]            w_occ_nxt;
   logic                  r_inflight;   // read accepted, data arrives this cycle
   logic                  r_run;        // low until the first edge after reset release
   logic                  w_rd;
   logic                  w_pop;
   logic                  w_cap;
   logic [DATA_WIDTH-1:0] r_buf0;       // head entry, drives m_data
   logic [DATA_WIDTH-1:0] r_buf1;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Read decision, buffer accounting and next state. A pop in the current
   // cycle frees a slot, so FULL still reads when the head word leaves; this
   // keeps one word per cycle flowing under continuous m_ready.
   always_comb begin
      w_pop       = (r_occ != 2'd0) & m_ready;
      w_cap       = r_inflight;
      w_rd        = r_run & en & ~fifo_empty & ((r_state != FULL) | w_pop);
      w_occ_nxt   = r_occ + 2'(w_cap) - 2'(w_pop);
      w_state_nxt = IDLE;
      if ((w_occ_nxt + 2'(w_rd)) == 2'd2) begin
         w_state_nxt = FULL;
      end else if (w_rd) begin
         w_state_nxt = READ;
      end
   end

   // Occupancy, in-flight flag and the two-entry output buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_run      <= 1'b0;
         r_buf0     <= '0;
         r_buf1     <= '0;
      end else begin
         r_run      <= 1'b1;
         r_occ      <= w_occ_nxt;
         r_inflight <= w_rd;
         if (w_pop) begin
            if (w_cap) begin
               if (r_occ == 2'd2) begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= fifo_data_out;
               end else begin
                  r_buf0 <= fifo_data_out;
               end
            end else begin
               r_buf0 <= r_buf1;
            end
         end else if (w_cap) begin
            if (r_occ == 2'd0) begin
               r_buf0 <= fifo_data_out;
            end else begin
               r_buf1 <= fifo_data_out;
            end
         end
      end
   end

`ifdef FIFO_RD_CNT_EN
   logic [CNT_WIDTH-1:0] r_cnt;

   // Delivered-word counter, free-running wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_pop) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign rd_cnt = r_cnt;
`endif

   // Chip-select and enable always travel together
   assign fifo_rd_cs = w_rd;
   assign fifo_rd_en = w_rd;
   assign m_valid    = (r_occ != 2'd0);
   assign m_data     = r_buf0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_ctrl
// Brief    : Self-checking bench for fifo_rd_ctrl with a behavioural sync_fifo
//            (read latency 1) and a scoreboard of expected output words.
//            Counter checks are active when FIFO_RD_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk        = 1'b0;
   logic          rst        = 1'b0;
   logic          en         = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          m_ready    = 1'b0;
   logic [DW-1:0] fifo_dout  = '0;
   logic          fifo_rd_cs;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] cnt_exp = '0;
`endif

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] sb_word;
   logic          rd_pend  = 1'b0;
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_reads  = 0;
   int            n_pops   = 0;
   int            r0;
   int            p0;

   fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_data_out(fifo_dout),
      .fifo_rd_cs   (fifo_rd_cs),
      .fifo_rd_en   (fifo_rd_en),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data)
`ifdef FIFO_RD_CNT_EN
      ,
      .rd_cnt       (rd_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      fifo_q.push_back(d);
      sb_q.push_back(d);
      fifo_empty = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      bit done = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !m_valid && fifo_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check("drain_done", 32'(done), 32'd1);
   endtask

   // Monitor: sample mid-cycle, score delivered words, note reads for the FIFO model
   always @(negedge clk) begin
      if (rst) begin
         if (fifo_rd_en) check("rd_cs_with_en", 32'(fifo_rd_cs), 32'd1);
         if (fifo_rd_cs) check("rd_en_with_cs", 32'(fifo_rd_en), 32'd1);
         if (fifo_rd_en) check("no_underflow", 32'(fifo_empty), 32'd0);
         rd_pend = fifo_rd_en & fifo_rd_cs & ~fifo_empty;
`ifdef FIFO_RD_CNT_EN
         check("rd_cnt_track", 32'(rd_cnt), 32'(cnt_exp));
`endif
         if (m_valid && m_ready) begin
            n_pops++;
`ifdef FIFO_RD_CNT_EN
            cnt_exp = cnt_exp + 4'd1;
`endif
            if (sb_q.size() == 0) begin
               check("sb_unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
               sb_word = sb_q.pop_front();
               check("sb_data", 32'(m_data), 32'(sb_word));
            end
         end
      end
   end

   // Behavioural sync_fifo: a read accepted at an edge presents its data after it
   always begin
      @(posedge clk);
      #1;
      if (rd_pend) begin
         rd_pend    = 1'b0;
         fifo_dout  = fifo_q.pop_front();
         fifo_empty = (fifo_q.size() == 0);
         n_reads++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit got;
      // ---------------- reset state ----------------
      m_ready = 1'b1;
      #2;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_rd_cs", 32'(fifo_rd_cs), 32'd0);
`ifdef FIFO_RD_CNT_EN
      check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
`endif
      push(8'h11);
      push(8'h22);
      push(8'h33);
      en = 1'b1;
      #3;
      check("rst_no_read_while_held", 32'(fifo_rd_en), 32'd0);
      repeat (2) tick();
      check("rst_no_read_after_edges", 32'(fifo_rd_en), 32'd0);
      rst = 1'b1;

      // ---------------- streaming ----------------
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (fifo_rd_en) begin
            got = 1'b1;
            break;
         end
      end
      check("stream_first_read", 32'(got), 32'd1);
      @(negedge clk);
      check("stream_lat_valid_lo", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("stream_w0_valid", 32'(m_valid), 32'd1);
      check("stream_w0_data", 32'(m_data), 32'h11);
      @(negedge clk);
      check("stream_w1_valid", 32'(m_valid), 32'd1);
      check("stream_w1_data", 32'(m_data), 32'h22);
      @(negedge clk);
      check("stream_w2_valid", 32'(m_valid), 32'd1);
      check("stream_w2_data", 32'(m_data), 32'h33);
      @(negedge clk);
      check("stream_done_valid", 32'(m_valid), 32'd0);
      check("stream_reads", 32'(n_reads), 32'd3);

      // ---------------- backpressure ----------------
      r0 = n_reads;
      tick();
      m_ready = 1'b0;
      push(8'hA1);
      push(8'hA2);
      push(8'hA3);
      push(8'hA4);
      repeat (6) @(negedge clk);
      check("bp_reads", 32'(n_reads - r0), 32'd2);
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_data", 32'(m_data), 32'hA1);
      repeat (3) @(negedge clk);
      check("bp_data_held", 32'(m_data), 32'hA1);
      check("bp_reads_held", 32'(n_reads - r0), 32'd2);
      tick();
      m_ready = 1'b1;
      drain(30);
      check("bp_reads_total", 32'(n_reads - r0), 32'd4);

      // ---------------- empty boundary ----------------
      @(negedge clk);
      r0 = n_reads;
      p0 = n_pops;
      tick();
      push(8'h5C);
      repeat (6) @(negedge clk);
      check("empty_reads", 32'(n_reads - r0), 32'd1);
      check("empty_pops", 32'(n_pops - p0), 32'd1);
      check("empty_valid_lo", 32'(m_valid), 32'd0);
      check("empty_no_rd", 32'(fifo_rd_en), 32'd0);

      // ---------------- en drop ----------------
      @(negedge clk);
      r0 = n_reads;
      p0 = n_pops;
      tick();
      en = 1'b0;
      push(8'h71);
      push(8'h72);
      push(8'h73);
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      repeat (5) @(negedge clk);
      check("endrop_reads", 32'(n_reads - r0), 32'd1);
      check("endrop_pops", 32'(n_pops - p0), 32'd1);
      check("endrop_valid_lo", 32'(m_valid), 32'd0);

      // ---------------- reset mid-stream ----------------
      tick();
      m_ready = 1'b0;
      en      = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst_pre_reads", 32'(n_reads - r0), 32'd3);
      check("midrst_pre_valid", 32'(m_valid), 32'd1);
      check("midrst_pre_data", 32'(m_data), 32'h72);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_valid", 32'(m_valid), 32'd0);
      check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("midrst_m_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_CNT_EN
      check("midrst_rd_cnt", 32'(rd_cnt), 32'd0);
      cnt_exp = '0;
`endif
      fifo_q.delete();
      sb_q.delete();
      fifo_empty = 1'b1;
      rd_pend    = 1'b0;
      repeat (2) tick();
      rst     = 1'b1;
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("postrst_valid", 32'(m_valid), 32'd0);

`ifdef FIFO_RD_CNT_EN
      // ---------------- counter wrap ----------------
      tick();
      for (int i = 0; i < 17; i++) push(8'(8'h30 + i));
      drain(60);
      check("cnt_wrap", 32'(rd_cnt), 32'd1);
`endif

      // ---------------- random traffic ----------------
      for (int i = 0; i < 400; i++) begin
         tick();
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) push(8'($urandom_range(0, 255)));
         m_ready = ($urandom_range(0, 3) != 0);
         en      = ($urandom_range(0, 5) != 0);
      end
      tick();
      en      = 1'b1;
      m_ready = 1'b1;
      drain(50);
      check("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
